// File: rtl/sobel_window_stream_pkg.sv
// Shared types for the column-serial Sobel window stream: geometry, window layout and FSM states.
// The window typedefs are sized by SOBEL_PIXEL_W, so the PIXEL_W parameter of the blocks must match it.
package sobel_window_stream_pkg;

  localparam int SOBEL_PIXEL_W    = 8;
  localparam int SOBEL_LINE_W     = 10;
  localparam int SOBEL_WIN_N      = 3;
  localparam int SOBEL_PX_PER_COL = 3;
  localparam int SOBEL_FILL_PX    = SOBEL_WIN_N * SOBEL_PX_PER_COL;

  typedef logic [SOBEL_PIXEL_W-1:0] sobel_px_t;

  typedef struct packed {
    sobel_px_t row2;
    sobel_px_t row1;
    sobel_px_t row0;
  } sobel_col_t;

  typedef struct packed {
    sobel_col_t col2;
    sobel_col_t col1;
    sobel_col_t col0;
  } sobel_win_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SLIDE = 2'd2
  } state_t;

endpackage

// File: rtl/sobel_window_stream_mag_core.sv
// Combinational Sobel |Gx|+|Gy| over a 3x3 window, then saturation (mode 0) or threshold (mode 1).
// Zero latency; no flow control of its own.
module sobel_mag_core
  import sobel_window_stream_pkg::*;
#(
  parameter int PIXEL_W = SOBEL_PIXEL_W
) (
  input  sobel_win_t         win_i,
  input  logic               mode_i,
  input  logic [PIXEL_W-1:0] thresh_i,
  output logic [PIXEL_W-1:0] px_o
);

  localparam int GW = PIXEL_W + 3;
  localparam int MW = PIXEL_W + 4;

  function automatic logic [GW-1:0] wsum(input logic [PIXEL_W-1:0] a, b, c);
    return GW'(a) + (GW'(b) << 1) + GW'(c);
  endfunction

  // |G| never exceeds 4*(2^PIXEL_W-1), so the negation cannot overflow GW bits
  function automatic logic [GW-1:0] absv(input logic [GW-1:0] v);
    return v[GW-1] ? (~v + GW'(1)) : v;
  endfunction

  logic [GW-1:0] gx;
  logic [GW-1:0] gy;
  logic [MW-1:0] mag;

  always_comb begin
    gx  = wsum(win_i.col2.row0, win_i.col2.row1, win_i.col2.row2)
        - wsum(win_i.col0.row0, win_i.col0.row1, win_i.col0.row2);
    gy  = wsum(win_i.col0.row2, win_i.col1.row2, win_i.col2.row2)
        - wsum(win_i.col0.row0, win_i.col1.row0, win_i.col2.row0);
    mag = MW'(absv(gx)) + MW'(absv(gy));
    if (mode_i) begin
      px_o = (mag >= MW'(thresh_i)) ? '1 : '0;
    end else begin
      px_o = (mag > MW'({PIXEL_W{1'b1}})) ? '1 : mag[PIXEL_W-1:0];
    end
  end

endmodule

// File: rtl/sobel_window_stream.sv
// Column-serial 3x3 Sobel window controller: builds/slides the window, one edge pixel per window.
// Output registered 1 cycle after the completing pixel; input stalls only while a finished window waits on a full output.
module sobel_window_stream
  import sobel_window_stream_pkg::*;
#(
  parameter int PIXEL_W = SOBEL_PIXEL_W,
  parameter int LINE_W  = SOBEL_LINE_W
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic               start_i,
  input  logic [LINE_W-1:0]  line_len_i,
  input  logic               cfg_mode_i,
  input  logic [PIXEL_W-1:0] cfg_thresh_i,
  input  logic               px_valid_i,
  input  logic [PIXEL_W-1:0] px_i,
  output logic               px_ready_o,
  output logic               px_valid_o,
  output logic [PIXEL_W-1:0] px_o,
  input  logic               px_ready_i,
  output logic               eol_o,
  output logic               busy_o
);

  localparam logic [3:0] FILL_LAST  = 4'(SOBEL_FILL_PX - 1);
  localparam logic [3:0] SLIDE_LAST = 4'(SOBEL_PX_PER_COL - 1);

  state_t             state_q, state_d;
  logic [3:0]         pix_cnt_q, pix_cnt_d;
  logic [LINE_W-1:0]  win_cnt_q, win_cnt_d;
  logic [LINE_W-1:0]  line_len_q;
  logic               mode_q;
  logic [PIXEL_W-1:0] thresh_q;
  sobel_win_t         win_q, win_d;
  logic               win_vld_q, win_vld_d;
  logic               win_eol_q, win_eol_d;
  logic               out_vld_q, out_vld_d;
  logic               out_eol_q, out_eol_d;
  logic [PIXEL_W-1:0] out_px_q, out_px_d;
  logic [PIXEL_W-1:0] core_px;
  logic               out_free, px_xfer, win_done, eol_hit;

  assign out_free = !out_vld_q || px_ready_i;
  assign px_xfer  = px_valid_i && px_ready_o;
  assign win_done = px_xfer && (pix_cnt_q == ((state_q == FILL) ? FILL_LAST : SLIDE_LAST));
  assign eol_hit  = (line_len_q != '0) && ((win_cnt_q + LINE_W'(1)) == line_len_q);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = FILL;
      FILL:    if (win_done) state_d = eol_hit ? FILL : SLIDE;
      SLIDE:   if (win_done && eol_hit) state_d = FILL;
      default: state_d = IDLE;
    endcase
    if (!start_i) state_d = IDLE;
  end

  always_comb begin
    px_ready_o = ((state_q == FILL) || (state_q == SLIDE)) && (!win_vld_q || out_free);
    busy_o     = (state_q != IDLE) || out_vld_q;
  end

  // The core sees the pre-edge window, so a shift on the hand-off edge is safe
  always_comb begin
    win_d     = win_q;
    pix_cnt_d = pix_cnt_q;
    win_cnt_d = win_cnt_q;
    win_vld_d = win_vld_q && !out_free;
    win_eol_d = win_eol_q;
    if (px_xfer) begin
      pix_cnt_d = win_done ? '0 : pix_cnt_q + 4'd1;
      if (state_q == FILL) begin
        case (pix_cnt_q)
          4'd0:    win_d.col0.row0 = px_i;
          4'd1:    win_d.col0.row1 = px_i;
          4'd2:    win_d.col0.row2 = px_i;
          4'd3:    win_d.col1.row0 = px_i;
          4'd4:    win_d.col1.row1 = px_i;
          4'd5:    win_d.col1.row2 = px_i;
          4'd6:    win_d.col2.row0 = px_i;
          4'd7:    win_d.col2.row1 = px_i;
          default: win_d.col2.row2 = px_i;
        endcase
      end else begin
        case (pix_cnt_q)
          4'd0: begin
            win_d.col0      = win_q.col1;
            win_d.col1      = win_q.col2;
            win_d.col2.row0 = px_i;
          end
          4'd1:    win_d.col2.row1 = px_i;
          default: win_d.col2.row2 = px_i;
        endcase
      end
    end
    if (win_done) begin
      win_vld_d = 1'b1;
      win_eol_d = eol_hit;
      win_cnt_d = eol_hit ? '0 : win_cnt_q + LINE_W'(1);
    end
    if (!start_i) begin
      pix_cnt_d = '0;
      win_cnt_d = '0;
      win_vld_d = 1'b0;
    end
  end

  sobel_mag_core #(.PIXEL_W(PIXEL_W)) u_core (
    .win_i   (win_q),
    .mode_i  (mode_q),
    .thresh_i(thresh_q),
    .px_o    (core_px)
  );

  always_comb begin
    out_vld_d = out_vld_q;
    out_px_d  = out_px_q;
    out_eol_d = out_eol_q;
    if (out_free) begin
      out_vld_d = win_vld_q;
      out_eol_d = win_vld_q && win_eol_q;
      if (win_vld_q) out_px_d = core_px;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      pix_cnt_q  <= '0;
      win_cnt_q  <= '0;
      line_len_q <= '0;
      mode_q     <= 1'b0;
      thresh_q   <= '0;
      win_q      <= '0;
      win_vld_q  <= 1'b0;
      win_eol_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_eol_q  <= 1'b0;
      out_px_q   <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      win_cnt_q <= win_cnt_d;
      win_q     <= win_d;
      win_vld_q <= win_vld_d;
      win_eol_q <= win_eol_d;
      out_vld_q <= out_vld_d;
      out_eol_q <= out_eol_d;
      out_px_q  <= out_px_d;
      if ((state_q == IDLE) && start_i) begin
        line_len_q <= line_len_i;
        mode_q     <= cfg_mode_i;
        thresh_q   <= cfg_thresh_i;
      end
    end
  end

  assign px_valid_o = out_vld_q;
  assign px_o       = out_px_q;
  assign eol_o      = out_eol_q;

endmodule

// File: tb/tb_sobel_window_stream.sv
// Directed bench for sobel_window_stream with an output scoreboard fed by a small Sobel model.
module tb_sobel_window_stream;

  logic       clk_i = 1'b0;
  logic       nreset_i;
  logic       start_i;
  logic [9:0] line_len_i;
  logic       cfg_mode_i;
  logic [7:0] cfg_thresh_i;
  logic       px_valid_i;
  logic [7:0] px_i;
  logic       px_ready_o;
  logic       px_valid_o;
  logic [7:0] px_o;
  logic       px_ready_i;
  logic       eol_o;
  logic       busy_o;

  sobel_window_stream dut (
    .clk_i       (clk_i),
    .nreset_i    (nreset_i),
    .start_i     (start_i),
    .line_len_i  (line_len_i),
    .cfg_mode_i  (cfg_mode_i),
    .cfg_thresh_i(cfg_thresh_i),
    .px_valid_i  (px_valid_i),
    .px_i        (px_i),
    .px_ready_o  (px_ready_o),
    .px_valid_o  (px_valid_o),
    .px_o        (px_o),
    .px_ready_i  (px_ready_i),
    .eol_o       (eol_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] px;
    logic       eol;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   mcol[3][3];
  int   mfill, mwin, mlen, mmode, mthr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_px();
    int w[3] = '{1, 2, 1};
    int gx = 0;
    int gy = 0;
    int mag;
    for (int r = 0; r < 3; r++) gx += w[r] * (mcol[2][r] - mcol[0][r]);
    for (int c = 0; c < 3; c++) gy += w[c] * (mcol[c][2] - mcol[c][0]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mmode != 0) return (mag >= mthr) ? 255 : 0;
    return (mag > 255) ? 255 : mag;
  endfunction

  // Scoreboard consumer: compare every accepted output beat
  always @(negedge clk_i) begin
    if (nreset_i === 1'b1 && px_valid_o === 1'b1 && px_ready_i === 1'b1) begin
      checks++;
      assert (sb_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_output: observed px %0h expected no output", px_o);
      end
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("sb_px", 32'(px_o), 32'(mon_e.px));
        chk("sb_eol", 32'(eol_o), 32'(mon_e.eol));
      end
    end
  end

  task automatic send_px(input logic [7:0] p);
    int n = 0;
    px_i       = p;
    px_valid_i = 1'b1;
    @(negedge clk_i);
    while (px_ready_o !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    checks++;
    assert (n < 100) else begin
      errors++;
      $error("FAIL px_ready_timeout: observed %0d cycles expected < 100", n);
    end
    @(posedge clk_i);
    #1;
    px_valid_i = 1'b0;
  endtask

  task automatic send_col(input int a, input int b, input int c);
    exp_t e;
    send_px(8'(a));
    send_px(8'(b));
    send_px(8'(c));
    for (int r = 0; r < 3; r++) begin
      mcol[0][r] = mcol[1][r];
      mcol[1][r] = mcol[2][r];
    end
    mcol[2][0] = a;
    mcol[2][1] = b;
    mcol[2][2] = c;
    mfill++;
    if (mfill >= 3) begin
      mwin++;
      e.px  = 8'(model_px());
      e.eol = (mlen != 0) && (mwin == mlen);
      sb_q.push_back(e);
      if (e.eol) begin
        mfill = 0;
        mwin  = 0;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      n++;
      @(posedge clk_i);
    end
    #1;
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic restart(input int len, input int mode, input int thr);
    drain();
    start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    line_len_i   = 10'(len);
    cfg_mode_i   = mode[0];
    cfg_thresh_i = 8'(thr);
    start_i      = 1'b1;
    @(posedge clk_i);
    #1;
    mfill = 0;
    mwin  = 0;
    mlen  = len;
    mmode = mode;
    mthr  = thr;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset_i     = 1'b0;
    start_i      = 1'b0;
    line_len_i   = '0;
    cfg_mode_i   = 1'b0;
    cfg_thresh_i = '0;
    px_valid_i   = 1'b0;
    px_i         = '0;
    px_ready_i   = 1'b1;
    mfill = 0; mwin = 0; mlen = 0; mmode = 0; mthr = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_px_valid_o", 32'(px_valid_o), 32'd0);
    chk("rst_px_ready_o", 32'(px_ready_o), 32'd0);
    chk("rst_busy_o", 32'(busy_o), 32'd0);
    chk("rst_eol_o", 32'(eol_o), 32'd0);
    chk("rst_px_o", 32'(px_o), 32'd0);
    nreset_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("idle_ready_low", 32'(px_ready_o), 32'd0);

    // Flat window, mode 0, with output latency check
    restart(0, 0, 0);
    chk("fill_ready_high", 32'(px_ready_o), 32'd1);
    chk("fill_busy", 32'(busy_o), 32'd1);
    send_col(100, 100, 100);
    send_col(100, 100, 100);
    send_col(100, 100, 100);
    chk("lat_not_yet", 32'(px_valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    chk("lat_one_cycle", 32'(px_valid_o), 32'd1);

    // Saturation
    restart(0, 0, 0);
    send_col(0, 0, 0);
    send_col(0, 0, 0);
    send_col(255, 255, 255);

    // Threshold on both sides of mag = 80
    restart(0, 1, 80);
    send_col(0, 0, 0);
    send_col(10, 10, 10);
    send_col(20, 20, 20);
    restart(0, 1, 81);
    send_col(0, 0, 0);
    send_col(10, 10, 10);
    send_col(20, 20, 20);

    // Asymmetric windows exercise Gy and the slide
    restart(0, 0, 0);
    send_col(10, 20, 30);
    send_col(0, 50, 90);
    send_col(200, 5, 7);
    send_col(60, 60, 60);
    send_col(3, 9, 1);

    // Line length 3: eol on the third window, then re-prime
    restart(3, 0, 0);
    send_col(5, 40, 80);
    send_col(90, 10, 0);
    send_col(30, 30, 200);
    send_col(7, 7, 7);
    send_col(120, 60, 15);
    drain();
    send_col(1, 2, 3);
    send_col(40, 50, 60);
    repeat (4) @(posedge clk_i);
    #1;
    chk("reprime_no_output", 32'(px_valid_o), 32'd0);
    send_col(9, 90, 99);

    // Output backpressure: input stalls after the second window, order kept
    restart(0, 0, 0);
    px_ready_i = 1'b0;
    send_col(0, 0, 0);
    send_col(0, 0, 0);
    send_col(50, 50, 50);
    send_col(10, 70, 250);
    repeat (3) @(posedge clk_i);
    #1;
    chk("bp_ready_low", 32'(px_ready_o), 32'd0);
    chk("bp_valid_held", 32'(px_valid_o), 32'd1);
    chk("bp_px_first", 32'(px_o), 32'(sb_q[0].px));
    repeat (2) @(posedge clk_i);
    #1;
    chk("bp_px_stable", 32'(px_o), 32'(sb_q[0].px));
    chk("bp_queue_depth", 32'(sb_q.size()), 32'd2);
    px_ready_i = 1'b1;
    drain();
    chk("bp_ready_back", 32'(px_ready_o), 32'd1);

    // start_i dropped mid-fill: partial window discarded
    restart(0, 0, 0);
    for (int i = 0; i < 5; i++) send_px(8'(30 * i));
    start_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_ready", 32'(px_ready_o), 32'd0);
    restart(0, 0, 0);
    send_col(200, 200, 200);
    send_col(100, 100, 100);
    repeat (4) @(posedge clk_i);
    #1;
    chk("restart_needs_9", 32'(px_valid_o), 32'd0);
    send_col(0, 0, 0);

    // Asynchronous reset while an output is pending
    restart(0, 0, 0);
    px_ready_i = 1'b0;
    send_col(0, 0, 0);
    send_col(0, 0, 0);
    send_col(40, 40, 40);
    @(posedge clk_i);
    #1;
    chk("pre_rst_valid", 32'(px_valid_o), 32'd1);
    @(negedge clk_i);
    nreset_i = 1'b0;
    #1;
    chk("arst_valid", 32'(px_valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    sb_q.delete();
    start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    nreset_i   = 1'b1;
    px_ready_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #1;
    chk("post_rst_valid", 32'(px_valid_o), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
